mips_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the EX stage of the pipelined MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO at XLEN data width.
- Uses a valid/ready request handshake, a busy flag for the hazard unit to stall MFHI/MFLO, and a flush input to squash in-flight ops on branch or jump redirect.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mips_muldiv_step.sv | 42 ++++
 rtl/mips_muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the EX-stage multiply/divide path.
// Holds the mul/div unit op encoding, the unit's FSM state encoding and the
// R-type funct codes that the decoder maps onto those ops.
package mips_pkg;

  // Op encoding on req_op_i; 3'b11x is accepted as a no-op.
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // R-type funct field values used by decode.
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration of the iterative multiply/divide datapath.
// The 2*XLEN accumulator is shared by both operations:
//   multiply: {partial product high, remaining multiplier bits} -> shift-add
//   divide:   {partial remainder, dividend/quotient bits}      -> restore-subtract
// Ports:
//   is_div_i  select divide (1) or multiply (0) iteration
//   acc_i     current accumulator
//   opb_i     multiplicand (multiply) or divisor (divide), magnitude form
//   acc_o     accumulator after this iteration
module mips_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_s;
  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] diff_s;

  // Single shift-add or restoring-divide step.
  always_comb begin
    add_s    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : {(XLEN+1){1'b0}});
    // Remainder shifted left with the next dividend bit brought in.
    rem_sh_s = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    // Remainder < divisor, so the difference fits in XLEN bits when
    // non-negative and bit XLEN is a reliable borrow flag.
    diff_s   = rem_sh_s - {1'b0, opb_i};
    if (is_div_i) begin
      if (!diff_s[XLEN]) begin
        acc_o = {diff_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh_s[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {add_s, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the EX stage.
// Signed ops run on magnitudes; the sign is restored in the single FIX cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid_i/ready_o  request handshake (ready only in IDLE)
//   req_op_i             op code (mips_pkg::md_op_e, 11x = no-op)
//   rs_val_i, rt_val_i   forwarded operands
//   flush_i              squash in-flight op / drop same-cycle request
//   busy_o               unit not IDLE (hazard unit stalls MFHI/MFLO)
//   done_o               one-cycle pulse when a mul/div wrote HI/LO
//   hi_o, lo_o           HI/LO registers
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] rs_val_i,
  input  logic [XLEN-1:0] rt_val_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(XLEN);

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + ONE_X;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + ONE_2X;
  endfunction

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc_s;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   rs_q, rs_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;     // negate product / quotient
  logic              rneg_q, rneg_d;   // negate remainder (dividend sign)
  logic              dz_q, dz_d;       // divide by zero
  logic              done_q, done_d;

  logic              accept_s;
  logic              signed_op_s;
  logic [XLEN-1:0]   rs_mag_s, rt_mag_s;

  assign accept_s    = req_valid_i && (state_q == IDLE) && !flush_i;
  assign signed_op_s = ~req_op_i[0];
  assign rs_mag_s    = (signed_op_s && rs_val_i[XLEN-1]) ? neg_x(rs_val_i) : rs_val_i;
  assign rt_mag_s    = (signed_op_s && rt_val_i[XLEN-1]) ? neg_x(rt_val_i) : rt_val_i;

  mips_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (step_acc_s)
  );

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    rs_d     = rs_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (req_op_i)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d  = CALC;
              cnt_d    = CNT_LOAD;
              acc_d    = {{XLEN{1'b0}}, rs_mag_s};
              opb_d    = rt_mag_s;
              rs_d     = rs_val_i;
              is_div_d = req_op_i[1];
              neg_d    = signed_op_s & (rs_val_i[XLEN-1] ^ rt_val_i[XLEN-1]);
              rneg_d   = signed_op_s & req_op_i[1] & rs_val_i[XLEN-1];
              dz_d     = req_op_i[1] & (rt_val_i == {XLEN{1'b0}});
            end
            MD_MTHI: hi_d = rs_val_i;
            MD_MTLO: lo_d = rs_val_i;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = step_acc_s;
        cnt_d = cnt_q - CNT_ONE;
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (flush_i) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = neg_q ? neg_2x(acc_q) : acc_q;
          end else if (dz_q) begin
            lo_d = {XLEN{1'b1}};
            hi_d = rs_q;
          end else begin
            // MIN / -1 falls out naturally: |MIN| = MIN and its negation is MIN.
            lo_d = neg_q  ? neg_x(acc_q[XLEN-1:0])      : acc_q[XLEN-1:0];
            hi_d = rneg_q ? neg_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and architectural register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      opb_q    <= {XLEN{1'b0}};
      rs_q     <= {XLEN{1'b0}};
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      rs_q     <= rs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  // Status is decoded from the state register only, never from the request.
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (XLEN=32 and XLEN=8 instances).
// Expected HI/LO pairs go into a scoreboard queue when a request is issued and
// are popped when done_o pulses.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs = 32'h0, rt = 32'h0;
  logic        ready, busy, done;
  logic [31:0] hi, lo;

  logic        valid8 = 1'b0, flush8 = 1'b0;
  logic [2:0]  op8 = 3'b000;
  logic [7:0]  rs8 = 8'h0, rt8 = 8'h0;
  logic        ready8, busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [15:0] sb8_q[$];

  always #5 clk = ~clk;

  mips_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid), .req_ready_o(ready),
    .req_op_i(op), .rs_val_i(rs), .rt_val_i(rt), .flush_i(flush),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  mips_muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid8), .req_ready_o(ready8),
    .req_op_i(op8), .rs_val_i(rs8), .rt_val_i(rt8), .flush_i(flush8),
    .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
  );

  // Reference model of the architectural result {HI,LO}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'h0;
    case (o)
      3'd0: res = sa * sb;
      3'd1: res = {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      end
      3'd3: begin
        if (b == 32'h0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'h0;
    endcase
    return res;
  endfunction

  // Present one request for one cycle; returns just after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Wait (bounded) for done_o; edges counted after the accept edge, -1 on timeout.
  // busy_ok is cleared if busy_o drops before done_o or is still high at done_o.
  task automatic wait_done(output int edges, output bit busy_ok);
    bit seen;
    seen = 1'b0; edges = 0; busy_ok = busy;
    for (int i = 0; i < 60; i++) begin
      if (!seen) begin
        @(posedge clk); #1;
        edges++;
        seen = done;
        if (!seen && !busy) busy_ok = 1'b0;
        if (seen && busy) busy_ok = 1'b0;
      end
    end
    if (!seen) edges = -1;
  endtask

  task automatic pop_check(input string name);
    logic [63:0] exp;
    exp = sb_q.pop_front();
    n_vec++;
    if ({hi, lo} !== exp) begin
      n_err++;
      $display("FAIL %s: hi/lo got %h_%h expected %h_%h", name, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL reset_hilo: got %h %h expected 0 0", hi, lo); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b %b expected 0 0", busy, done); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_mul_latency;
    int e; bit bok;
    sb_q.push_back(64'hFFFFFFFE_00000001);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(e, bok);
    // Count includes the accept edge itself.
    n_vec++; if (e + 1 !== 34) begin n_err++; $display("FAIL multu_latency: got %0d edges expected 34", e + 1); end
    n_vec++; if (!bok) begin n_err++; $display("FAIL multu_busy: busy profile got bad expected high until done"); end
    pop_check("multu_max");
  endtask

  task automatic test_signed;
    int e; bit bok;
    sb_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_done(e, bok);
    pop_check("mult_neg");
    sb_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(e, bok);
    pop_check("div_neg");
  endtask

  task automatic test_div_corner;
    int e; bit bok;
    sb_q.push_back(64'h00000007_FFFFFFFF);
    issue(3'd3, 32'd7, 32'd0);
    wait_done(e, bok);
    n_vec++; if (e + 1 !== 34) begin n_err++; $display("FAIL divz_latency: got %0d edges expected 34", e + 1); end
    pop_check("divu_by_zero");
    sb_q.push_back(64'h00000000_80000000);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(e, bok);
    pop_check("div_overflow");
  endtask

  task automatic test_flush;
    bit seen;
    issue(3'd4, 32'h1234, 32'h0);
    n_vec++; if (hi !== 32'h1234 || busy !== 1'b0) begin n_err++; $display("FAIL mthi: got hi=%h busy=%b expected 1234 0", hi, busy); end
    issue(3'd5, 32'h5678, 32'h0);
    n_vec++; if (lo !== 32'h5678 || done !== 1'b0) begin n_err++; $display("FAIL mtlo: got lo=%h done=%b expected 5678 0", lo, done); end
    issue(3'd2, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    n_vec++; if (busy !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL flush_calc: got busy=%b ready=%b expected 0 1", busy, ready); end
    seen = 1'b0;
    repeat (36) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    n_vec++; if (seen || hi !== 32'h1234 || lo !== 32'h5678) begin n_err++; $display("FAIL flush_nowrite: got done=%b hi=%h lo=%h expected 0 1234 5678", seen, hi, lo); end
    @(negedge clk); valid = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd3; flush = 1'b1;
    @(posedge clk); #1 valid = 1'b0; flush = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_drop_mul: got busy=%b expected 0", busy); end
    @(negedge clk); valid = 1'b1; op = 3'd4; rs = 32'hDEAD; flush = 1'b1;
    @(posedge clk); #1 valid = 1'b0; flush = 1'b0;
    n_vec++; if (hi !== 32'h1234) begin n_err++; $display("FAIL flush_drop_mt: got hi=%h expected 1234", hi); end
  endtask

  task automatic test_fix_flush;
    issue(3'd1, 32'd3, 32'd3);
    repeat (32) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    n_vec++; if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin
      n_err++; $display("FAIL fix_flush: got done=%b busy=%b hi=%h lo=%h expected 0 0 1234 5678", done, busy, hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int e; bit bok;
    sb_q.push_back(64'h00000001_00000004);
    issue(3'd3, 32'd9, 32'd2);
    wait_done(e, bok);
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b expected 1", ready); end
    pop_check("b2b_divu");
    // New request in the done_o cycle itself.
    sb_q.push_back(64'h00000000_0000002A);
    valid = 1'b1; op = 3'd1; rs = 32'd6; rt = 32'd7;
    @(posedge clk); #1 valid = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    wait_done(e, bok);
    n_vec++; if (e + 1 !== 34) begin n_err++; $display("FAIL b2b_latency: got %0d edges expected 34", e + 1); end
    pop_check("b2b_multu");
  endtask

  task automatic test_random;
    int e; bit bok;
    logic [2:0] o; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      sb_q.push_back(model(o, a, b));
      issue(o, a, b);
      wait_done(e, bok);
      pop_check("random");
    end
  endtask

  task automatic test_reset_midop;
    issue(3'd4, 32'hABCD, 32'h0);
    issue(3'd0, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL async_rst_hilo: got %h %h expected 0 0", hi, lo); end
    n_vec++; if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL async_rst_state: got busy=%b ready=%b done=%b expected 0 1 0", busy, ready, done); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_xlen8;
    logic [2:0]  ops [2] = '{3'd1, 3'd2};
    logic [7:0]  as  [2] = '{8'hFF, 8'h80};
    logic [7:0]  bs  [2] = '{8'hFF, 8'hFF};
    logic [15:0] exps[2] = '{16'hFE01, 16'h0080};
    logic [15:0] exp;
    int e; bit seen;
    for (int k = 0; k < 2; k++) begin
      sb8_q.push_back(exps[k]);
      @(negedge clk); valid8 = 1'b1; op8 = ops[k]; rs8 = as[k]; rt8 = bs[k];
      @(posedge clk); #1 valid8 = 1'b0;
      seen = 1'b0; e = 0;
      for (int i = 0; i < 30; i++) begin
        if (!seen) begin @(posedge clk); #1; e++; seen = done8; end
      end
      if (!seen) e = -1;
      n_vec++; if (e + 1 !== 10) begin n_err++; $display("FAIL x8_latency: got %0d edges expected 10", e + 1); end
      exp = sb8_q.pop_front();
      n_vec++; if ({hi8, lo8} !== exp) begin n_err++; $display("FAIL x8_result: got %h_%h expected %h_%h", hi8, lo8, exp[15:8], exp[7:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_signed();
    test_div_corner();
    test_flush();
    test_fix_flush();
    test_back_to_back();
    test_random();
    test_reset_midop();
    test_xlen8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
